// File: rtl/hidman_zx_pkg.sv
// Shared constants and types for the HIDman ZX Spectrum bus front end.
package hidman_zx_pkg;

    // Low address bytes decoded for the Kempston mouse and joystick ports
    localparam logic [7:0] MOUSE_PORT     = 8'hDF;
    localparam logic [7:0] JOY_PORT       = 8'h1F;

    localparam logic [7:0] X_RESET        = 8'h80;
    localparam logic [7:0] Y_RESET        = 8'h60;
    localparam logic [7:0] BUTTONS_RESET  = 8'hAA;
    localparam logic [7:0] JOY_RESET      = 8'h00;
    localparam logic [7:0] BUTTONS_FORCED = 8'h08;

    localparam int KEY_COLS = 8;
    localparam int KEY_ROWS = 5;

    localparam logic [2:0] KEY_Y_MAX = 3'd4;
    localparam logic [3:0] SPECIAL_X = 4'd8;
    localparam logic [2:0] NMI_Y     = 3'd5;
    localparam logic [2:0] RST_OUT_Y = 3'd6;
    localparam logic [2:0] BSRQ_Y    = 3'd7;

    // Synchroniser lanes; the edge-detected lanes sit below the bus reset lane
    localparam int LANE_MX     = 0;
    localparam int LANE_MY     = 1;
    localparam int LANE_MKEY   = 2;
    localparam int LANE_JOY    = 3;
    localparam int LANE_SK     = 4;
    localparam int LANE_STB    = 5;
    localparam int LANE_RST_IN = 6;
    localparam int EDGE_LANES  = 6;
    localparam int SYNC_LANES  = 7;
    localparam logic [SYNC_LANES-1:0] SYNC_IDLE = 7'b100_0000;

    typedef struct packed {
        logic [2:0] y;
        logic [3:0] x;
    } cell_addr_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_BUTTONS,
        SRC_X,
        SRC_Y,
        SRC_JOY,
        SRC_KEYS
    } read_src_t;

    function automatic read_src_t mouse_reg(input logic a8, input logic a10);
        if (!a8) return SRC_BUTTONS;
        return a10 ? SRC_Y : SRC_X;
    endfunction

endpackage

// File: rtl/zx_key_matrix.sv
// CH446Q-style serially loaded switch matrix: 40 keyboard cells plus the three
// special cells at X=8, which exist only when HIDMAN_ZX_SPECIAL_KEYS_EN is defined.
module zx_key_matrix
    import hidman_zx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                shift,
    input  logic                commit,
    input  logic                dat,
    input  logic [KEY_COLS-1:0] row_sel_n,
    output logic [KEY_ROWS-1:0] keys,
    output logic [2:0]          special
);

    cell_addr_t                        addr;
    logic                              key_hit;
    logic [KEY_COLS-1:0][KEY_ROWS-1:0] cells;

    // NOTE: non-blocking assignment means a commit on the same edge as a shift sees the pre-shift address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        addr <= '0;
        else if (clr)   addr <= '0;
        else if (shift) addr <= cell_addr_t'({addr[5:0], dat});
    end

    assign key_hit = !addr.x[3] && (addr.y <= KEY_Y_MAX);

    // NOTE: the store is only 40 bits and must come up all-open, so it is reset flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cells <= '1;
        else if (clr)               cells <= '1;
        else if (commit && key_hit) cells[addr.x[2:0]][addr.y] <= dat;
    end

    // NOTE: keys gets its default first so every path assigns it and no latch is inferred.
    always_comb begin
        keys = '1;
        for (int c = 0; c < KEY_COLS; c++) begin
            if (!row_sel_n[c]) keys = keys & cells[c];
        end
    end

`ifdef HIDMAN_ZX_SPECIAL_KEYS_EN
    logic [2:0] special_cells;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            special_cells <= '1;
        end else if (clr) begin
            special_cells <= '1;
        end else if (commit && addr.x == SPECIAL_X) begin
            case (addr.y)
                NMI_Y:     special_cells[0] <= dat;
                RST_OUT_Y: special_cells[1] <= dat;
                BSRQ_Y:    special_cells[2] <= dat;
                default:   ;
            endcase
        end
    end

    assign special = special_cells;
`else
    assign special = '1;
`endif

endmodule

// File: rtl/hidman_zx_bus_core.sv
// ZX Spectrum bus front end for HIDman: Kempston mouse/joystick registers, keyboard
// switch matrix and open-drain NMI/RST_OUT/BSRQ (live only with HIDMAN_ZX_SPECIAL_KEYS_EN).
module hidman_zx_bus_core
    import hidman_zx_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DI,
    input  logic        MX,
    input  logic        MY,
    input  logic        MKEY,
    input  logic        JOY,
    input  logic        JOY_ENABLE,
    input  logic [15:0] A,
    input  logic        M1,
    input  logic        RD,
    input  logic        IORQ,
    input  logic        RST_IN,
    input  logic        DAT,
    input  logic        SK,
    input  logic        STB,
    output logic [7:0]  D,
    output logic        IORQGE,
    output logic        NMI,
    output logic        RST_OUT,
    output logic        BSRQ
);

    logic [SYNC_LANES-1:0] sync_meta;
    logic [SYNC_LANES-1:0] sync_q;
    logic [EDGE_LANES-1:0] sync_prev;
    logic [EDGE_LANES-1:0] rise;
    logic                  bus_reset;

    logic [7:0] x_reg;
    logic [7:0] y_reg;
    logic [7:0] buttons_reg;
    logic [7:0] joy_reg;

    logic                mouse_hit;
    logic                joy_hit;
    logic                io_rd;
    read_src_t           src;
    logic [7:0]          d_val;
    logic                d_full;
    logic                d_low;
    logic [KEY_ROWS-1:0] keys;
    logic [2:0]          special;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_meta <= SYNC_IDLE;
            sync_q    <= SYNC_IDLE;
            sync_prev <= '0;
        end else begin
            sync_meta <= {RST_IN, STB, SK, JOY, MKEY, MY, MX};
            sync_q    <= sync_meta;
            sync_prev <= sync_q[EDGE_LANES-1:0];
        end
    end

    assign rise      = sync_q[EDGE_LANES-1:0] & ~sync_prev;
    assign bus_reset = !sync_q[LANE_RST_IN];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_reg       <= X_RESET;
            y_reg       <= Y_RESET;
            buttons_reg <= BUTTONS_RESET;
            joy_reg     <= JOY_RESET;
        end else if (bus_reset) begin
            x_reg       <= X_RESET;
            y_reg       <= Y_RESET;
            buttons_reg <= BUTTONS_RESET;
            joy_reg     <= JOY_RESET;
        end else begin
            if (rise[LANE_MX])   x_reg       <= DI;
            if (rise[LANE_MY])   y_reg       <= DI;
            if (rise[LANE_MKEY]) buttons_reg <= DI;
            if (rise[LANE_JOY])  joy_reg     <= DI;
        end
    end

    zx_key_matrix u_key_matrix (
        .clk       (CLK),
        .rst       (RST),
        .clr       (bus_reset),
        .shift     (rise[LANE_SK]),
        .commit    (rise[LANE_STB]),
        .dat       (DAT),
        .row_sel_n (A[15:8]),
        .keys      (keys),
        .special   (special)
    );

    // Keyboard reads only claim the bus when no Kempston port matches
    always_comb begin
        mouse_hit = (A[7:0] == MOUSE_PORT);
        joy_hit   = (A[7:0] == JOY_PORT) && !JOY_ENABLE;
        io_rd     = !IORQ && !RD;
        src       = SRC_NONE;
        if (io_rd && M1 && mouse_hit)                      src = mouse_reg(A[8], A[10]);
        else if (io_rd && M1 && joy_hit)                   src = SRC_JOY;
        else if (io_rd && !A[0] && !mouse_hit && !joy_hit) src = SRC_KEYS;
    end

    assign IORQGE = M1 && (mouse_hit || joy_hit);

    always_comb begin
        d_val  = '0;
        d_full = 1'b0;
        d_low  = 1'b0;
        case (src)
            SRC_BUTTONS: begin d_val = buttons_reg | BUTTONS_FORCED; d_full = 1'b1; end
            SRC_X:       begin d_val = x_reg;                        d_full = 1'b1; end
            SRC_Y:       begin d_val = y_reg;                        d_full = 1'b1; end
            SRC_JOY:     begin d_val = joy_reg;                      d_full = 1'b1; end
            SRC_KEYS:    begin d_val = {3'b000, keys};               d_low  = 1'b1; end
            default:     ;
        endcase
    end

    // Keyboard reads leave D[7:5] floating for the rest of the machine
    assign D[7:5] = d_full ? d_val[7:5] : 3'bzzz;
    assign D[4:0] = (d_full || d_low) ? d_val[4:0] : 5'bzzzzz;

    assign NMI     = special[0] ? 1'bz : 1'b0;
    assign RST_OUT = special[1] ? 1'bz : 1'b0;
    assign BSRQ    = special[2] ? 1'bz : 1'b0;

endmodule

// File: tb/tb_hidman_zx_bus_core.sv
// Scoreboard bench for hidman_zx_bus_core: every bus read pushes its expected D/IORQGE and
// open-drain levels (floating lines pulled high) from a behavioural model; a monitor compares.
module tb_hidman_zx_bus_core;

`ifdef HIDMAN_ZX_SPECIAL_KEYS_EN
    localparam bit SPECIAL_EN = 1'b1;
`else
    localparam bit SPECIAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  di;
    logic        mx, my, mkey, joy, joy_enable;
    logic [15:0] a;
    logic        m1, rd, iorq, rst_in, dat, sk, stb;
    wire  [7:0]  d_bus;
    wire         iorqge, nmi, rst_out, bsrq;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (d_bus[i]);
    end
    pullup (nmi);
    pullup (rst_out);
    pullup (bsrq);

    always #5 clk = ~clk;

    hidman_zx_bus_core dut (
        .CLK        (clk),
        .RST        (rst),
        .DI         (di),
        .MX         (mx),
        .MY         (my),
        .MKEY       (mkey),
        .JOY        (joy),
        .JOY_ENABLE (joy_enable),
        .A          (a),
        .M1         (m1),
        .RD         (rd),
        .IORQ       (iorq),
        .RST_IN     (rst_in),
        .DAT        (dat),
        .SK         (sk),
        .STB        (stb),
        .D          (d_bus),
        .IORQGE     (iorqge),
        .NMI        (nmi),
        .RST_OUT    (rst_out),
        .BSRQ       (bsrq)
    );

    // Behavioural model: register contents and open/closed state of every switch
    logic [7:0] m_x, m_y, m_buttons, m_joy;
    bit         key_open [8][5];
    bit         spec_open [3];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  d;
        logic        ge;
        logic [2:0]  od;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic model_reset();
        m_x = 8'h80; m_y = 8'h60; m_buttons = 8'hAA; m_joy = 8'h00;
        for (int xx = 0; xx < 8; xx++)
            for (int yy = 0; yy < 5; yy++) key_open[xx][yy] = 1'b1;
        for (int s = 0; s < 3; s++) spec_open[s] = 1'b1;
    endtask

    task automatic model_commit(input int y, input int x, input logic v);
        if (x < 8 && y < 5) key_open[x][y] = v;
        else if (SPECIAL_EN && x == 8 && y >= 5) spec_open[y-5] = v;
    endtask

    function automatic logic [7:0] exp_d(input logic [15:0] ad, input logic m);
        logic       mouse, joyp;
        logic [4:0] k;
        mouse = (ad[7:0] == 8'hDF);
        joyp  = (ad[7:0] == 8'h1F) && !joy_enable;
        if (m && mouse) begin
            if (!ad[8]) return m_buttons | 8'h08;
            return ad[10] ? m_y : m_x;
        end
        if (m && joyp) return m_joy;
        if (!ad[0] && !mouse && !joyp) begin
            k = 5'b11111;
            for (int xx = 0; xx < 8; xx++)
                if (!ad[8+xx])
                    for (int yy = 0; yy < 5; yy++)
                        if (!key_open[xx][yy]) k[yy] = 1'b0;
            return {3'b111, k};
        end
        return 8'hFF;
    endfunction

    function automatic logic exp_ge(input logic [15:0] ad, input logic m);
        return m && ((ad[7:0] == 8'hDF) || ((ad[7:0] == 8'h1F) && !joy_enable));
    endfunction

    always @(negedge clk) begin
        if (!iorq && !rd) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read a=%h d=%h (no expectation queued)", a, d_bus);
            end else begin
                mon_e = exp_q.pop_front();
                vectors++;
                if (d_bus !== mon_e.d || iorqge !== mon_e.ge || {bsrq, rst_out, nmi} !== mon_e.od) begin
                    miscompares++;
                    $display("FAIL %s a=%h: got d=%h ge=%b bsrq/rst/nmi=%b, want d=%h ge=%b bsrq/rst/nmi=%b",
                             mon_e.tag, mon_e.addr, d_bus, iorqge, {bsrq, rst_out, nmi},
                             mon_e.d, mon_e.ge, mon_e.od);
                end
            end
        end
    end

    // Every task below starts and ends 1 time unit after a rising clock edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic m1v, input string tag);
        exp_t e;
        a = addr; m1 = m1v; iorq = 1'b0; rd = 1'b0;
        e.addr = addr;
        e.d    = exp_d(addr, m1v);
        e.ge   = exp_ge(addr, m1v);
        e.od   = {spec_open[2], spec_open[1], spec_open[0]};
        e.tag  = tag;
        exp_q.push_back(e);
        tick(1);
        iorq = 1'b1; rd = 1'b1;
    endtask

    task automatic set_strobe(input int which, input logic v);
        case (which)
            0:       mx = v;
            1:       my = v;
            2:       mkey = v;
            default: joy = v;
        endcase
    endtask

    // which: 0=X, 1=Y, 2=buttons, 3=joystick; reads straddle the 3-CLK load latency
    task automatic write_reg(input int which, input logic [7:0] val);
        logic [15:0] probe;
        case (which)
            0:       probe = 16'hFBDF;
            1:       probe = 16'hFFDF;
            2:       probe = 16'hFADF;
            default: probe = 16'h001F;
        endcase
        di = val;
        set_strobe(which, 1'b1);
        repeat (3) bus_read(probe, 1'b1, "write_before");
        case (which)
            0:       m_x = val;
            1:       m_y = val;
            2:       m_buttons = val;
            default: m_joy = val;
        endcase
        bus_read(probe, 1'b1, "write_after");
        set_strobe(which, 1'b0);
        tick(3);
    endtask

    task automatic shift_bit(input logic b);
        dat = b; tick(2);
        sk = 1'b1; tick(3);
        sk = 1'b0; tick(2);
    endtask

    // Load (y,x) MSB-first and commit v; with_sk also raises SK on the commit edge
    task automatic load_cell(input int y, input int x, input logic v, input bit with_sk);
        logic [6:0]  word;
        logic [15:0] probe;
        logic [7:0]  one;
        word = {y[2:0], x[3:0]};
        for (int i = 6; i >= 0; i--) shift_bit(word[i]);
        one = 8'd1 << x[2:0];
        probe = (x < 8) ? {~one, 8'hFE} : 16'hFEFE;
        dat = v; tick(2);
        stb = 1'b1;
        if (with_sk) sk = 1'b1;
        repeat (3) bus_read(probe, 1'b1, "commit_before");
        model_commit(y, x, v);
        bus_read(probe, 1'b1, "commit_after");
        stb = 1'b0; sk = 1'b0;
        tick(2);
    endtask

    task automatic check_rows(input string tag);
        logic [7:0] one;
        for (int xx = 0; xx < 8; xx++) begin
            one = 8'd1 << xx;
            bus_read({~one, 8'hFE}, 1'b1, tag);
        end
        bus_read(16'h3FFE, 1'b1, tag);
        bus_read(16'h00FE, 1'b1, tag);
    endtask

    task automatic random_read();
        logic [15:0] ad;
        logic        m;
        int          k;
        k  = $urandom_range(0, 3);
        ad = 16'($urandom);
        m  = 1'b1;
        case (k)
            0:       begin ad[7:0] = 8'hDF; m = ($urandom_range(0, 3) != 0); end
            1:       begin ad[7:0] = 8'h1F; m = ($urandom_range(0, 3) != 0); end
            2:       ad[0] = 1'b0;
            default: ;
        endcase
        bus_read(ad, m, "random_read");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int kind;
        int ry, rx;
        rst = 1'b1; di = '0; mx = 0; my = 0; mkey = 0; joy = 0; joy_enable = 1'b0;
        a = 16'hFFFF; m1 = 1'b1; rd = 1'b1; iorq = 1'b1; rst_in = 1'b1;
        dat = 1'b0; sk = 1'b0; stb = 1'b0;
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(3);

        bus_read(16'hFBDF, 1'b1, "reset_x");
        bus_read(16'hFFDF, 1'b1, "reset_y");
        bus_read(16'hFADF, 1'b1, "reset_buttons");
        bus_read(16'h001F, 1'b1, "reset_joy");
        bus_read(16'hFEFE, 1'b1, "reset_row0");
        bus_read(16'h7FFE, 1'b1, "reset_row7");

        write_reg(0, 8'hCC);
        write_reg(1, 8'h55);
        write_reg(2, 8'hAA);
        write_reg(3, 8'hAA);
        bus_read(16'hFBDF, 1'b1, "read_x");
        bus_read(16'hFFDF, 1'b1, "read_y");
        bus_read(16'hFADF, 1'b1, "read_buttons");
        bus_read(16'h001F, 1'b1, "read_joy");
        joy_enable = 1'b1;
        bus_read(16'h001F, 1'b1, "joy_disabled");
        joy_enable = 1'b0;
        write_reg(2, 8'h00);
        bus_read(16'hFADF, 1'b0, "mouse_m1_low");

        load_cell(0, 0, 1'b0, 1'b0);
        load_cell(1, 1, 1'b0, 1'b0);
        load_cell(2, 2, 1'b0, 1'b0);
        load_cell(1, 3, 1'b0, 1'b0);
        load_cell(3, 3, 1'b0, 1'b0);
        load_cell(4, 4, 1'b0, 1'b0);
        load_cell(3, 5, 1'b0, 1'b0);
        load_cell(2, 6, 1'b0, 1'b0);
        load_cell(1, 7, 1'b0, 1'b0);
        check_rows("rows");

        load_cell(5, 8, 1'b0, 1'b0);
        load_cell(6, 8, 1'b0, 1'b0);
        load_cell(7, 8, 1'b0, 1'b0);
        load_cell(5, 8, 1'b1, 1'b0);
        load_cell(6, 8, 1'b1, 1'b0);
        load_cell(7, 8, 1'b1, 1'b0);
        load_cell(0, 12, 1'b0, 1'b0);
        load_cell(6, 2, 1'b0, 1'b0);
        check_rows("ignored_addr");

        // Bus reset in the middle of a shift, then a clean load
        for (int i = 6; i >= 3; i--) shift_bit(i[0]);
        rst_in = 1'b0; tick(4);
        model_reset();
        rst_in = 1'b1; tick(4);
        bus_read(16'hFBDF, 1'b1, "bus_reset_x");
        load_cell(2, 5, 1'b0, 1'b0);
        check_rows("after_bus_reset");

        for (int i = 0; i < 4; i++) shift_bit(1'b1);
        rst = 1'b1;
        model_reset();
        tick(2);
        rst = 1'b0; tick(2);
        load_cell(4, 0, 1'b0, 1'b0);
        check_rows("after_async_reset");

        load_cell(3, 6, 1'b0, 1'b1);
        load_cell(0, 7, 1'b0, 1'b1);
        check_rows("sk_with_stb");

        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                write_reg($urandom_range(0, 3), 8'($urandom));
            end else if (kind < 6) begin
                ry = $urandom_range(0, 7);
                rx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) :
                     (($urandom_range(0, 1) == 0) ? 8 : $urandom_range(9, 15));
                load_cell(ry, rx, ($urandom_range(0, 4) < 3) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 5) == 0));
            end else begin
                repeat (4) random_read();
            end
            if ($urandom_range(0, 7) == 0) joy_enable = ~joy_enable;
        end
        check_rows("final_rows");

        tick(2);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expectations got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hidman_zx_bus_core.md
# hidman_zx_bus_core

ZX Spectrum expansion-bus front end for the HIDman USB HID controller: holds Kempston mouse and Kempston joystick registers written by the HID microcontroller and returns them on Z80 port reads. It also emulates a CH446Q-style serially loaded switch matrix for the 40-key Spectrum keyboard, plus three special open-drain lines (NMI, reset, bus request). It sits between the HIDman MCU's parallel/serial outputs and the Spectrum edge connector.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- DI  in  8  MCU parallel data for register writes.
- MX, MY, MKEY, JOY  in  1 each  MCU write strobes (rising edge captures DI into X, Y, buttons, joystick register).
- JOY_ENABLE  in  1  active-low; high disables joystick port decode.
- A  in  16  Z80 address bus.
- M1, RD, IORQ  in  1 each  Z80 control, active-low (M1 must be high for an I/O read).
- RST_IN  in  1  Z80 bus reset, active-low; synchronised, then resets registers and matrix like RST.
- DAT, SK, STB  in  1 each  matrix serial data, shift clock, commit strobe.
- D  out(tri)  8  Z80 data bus.
- IORQGE  out  1  high when this block claims the current I/O address.
- NMI, RST_OUT, BSRQ  out(open-drain)  1 each  drive 0 or Z.

## Operation
- Reset values: X=0x80, Y=0x60, buttons=0xAA, joystick=0x00; all 43 matrix cells=1 (open); D, NMI, RST_OUT, BSRQ = Z; IORQGE follows decode.
- Register write: strobe rising edge loads DI. Buttons bit 3 always reads 1.
- Port read (IORQ=0, RD=0, M1=1), D driven with full byte:
  - A[7:0]=0xDF, A8=0 -> buttons (0xFADF); A8=1, A10=0 -> X (0xFBDF); A8=1, A10=1 -> Y (0xFFDF).
  - A[7:0]=0x1F and JOY_ENABLE=0 -> joystick.
- Keyboard read (IORQ=0, RD=0, A0=0, no mouse/joystick match): D[4:0] = bitwise AND of matrix rows X=0..7 whose A[8+X]=0; all ones if none selected; D[7:5]=Z.
- Otherwise D=Z.
- IORQGE = M1 & (mouse match | enabled joystick match), combinational on A/M1.
- Matrix load: each SK rising edge shifts DAT into 7-bit register MSB-first; order Y[2:0], X[3:0]. On STB rising edge, cell(Y,X) := DAT (0 = key closed).
- Valid cells: X 0..7 with Y 0..4 (keyboard; Y selects D[Y]). X=8: Y5=NMI, Y6=RST_OUT, Y7=BSRQ; output drives 0 while cell=0, else Z. All other addresses: commit ignored.

## Timing
- SK, STB, strobes, RST_IN: 2-flop synchronised, rising-edge detected; minimum high and low width 2 CLK each.
- Strobe edge to register visible on D: 3 CLK. STB edge to matrix/special output update: 3 CLK.
- DAT sampled at the synchronised SK/STB edge; must be stable 2 CLK before the edge and held 1 CLK after.
- Simultaneous SK and STB edges: commit uses the shift register value before the shift.
- Bus reads combinational from stored state; no CLK latency from A/RD/IORQ to D.
- Reset mid-shift discards partial shift and clears the shift register to 0.

## Configuration
- HIDMAN_ZX_SPECIAL_KEYS_EN defined: X=8 cells and NMI/RST_OUT/BSRQ behave as above.
- Undefined: X=8 commits ignored; NMI, RST_OUT, BSRQ permanently Z.

## Structure
- Package hidman_zx_pkg: port address constants, register reset values, special-key (Y,X) coordinates, matrix dimensions.
- One sub-module zx_key_matrix: shift register, STB commit, 40-cell keyboard store, special cells, row-select AND output.
- Top: synchronisers, MCU registers, address decode, D/IORQGE muxing, open-drain drivers.

## Test plan
- Reset, read 0xFBDF/0xFFDF/0xFADF/0x001F -> 0x80/0x60/0xAA/0x00.
- Write X=0xCC, Y=0x55, buttons=0xAA, joystick=0xAA; read 0xFBDF, 0xFFDF, 0xFADF, 0x001F -> 0xCC, 0x55, 0xAA, 0xAA; JOY_ENABLE=1 -> 0x001F reads Z, IORQGE=0.
- After reset A=0xFEFE and 0x7FFE -> D[4:0]=11111.
- Commit (0,0,0),(1,1,0),(2,2,0); row X3 Y0..4 = 1,0,1,0,1; (4,4,0),(3,5,0),(2,6,0),(1,7,0) -> rows FEFE..7FFE read 11110,11101,11011,10101,01111,10111,11011,11101; A=0x3FFE -> 11001.
- NMI, RST_OUT, BSRQ Z initially; commit (5,8,0),(6,8,0),(7,8,0) -> each 0 after 3 CLK; recommit with DAT=1 -> Z.
- Reset during partial 4-bit shift, then full 7-bit load and commit -> only the addressed cell changes.
